// File: rtl/ysyx_23060111_pkg.sv
// Shared encodings for the ysyx_23060111 load/store path:
// access sizes, LSU FSM states and base byte masks.
package ysyx_23060111_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_WRITE,
        LSU_READ,
        LSU_RESP
    } lsu_state_e;

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        return ((size == SZ_H) && off[0])
            || ((size == SZ_W) && (off != 2'd0))
            || (size == 2'd3);
    endfunction

endpackage

// File: rtl/ysyx_23060111_lsu_align.sv
// Byte-lane alignment: store data/mask shift and load extract/extend.
// Lanes shifted past byte 3 are dropped; size 3 behaves as a word.
module ysyx_23060111_lsu_align
    import ysyx_23060111_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        zext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] sdata,
    output logic [3:0]  smask,
    output logic [31:0] ldata
);

    logic [3:0]  mbase;
    logic [31:0] d;

    always_comb begin
        mbase = MASK_W;
        ldata = 32'd0;
        d     = rdata >> {off, 3'b000};
        unique case (size)
            SZ_B: begin
                mbase = MASK_B;
                ldata = zext ? {24'd0, d[7:0]}
                             : {{24{d[7]}}, d[7:0]};
            end
            SZ_H: begin
                mbase = MASK_H;
                ldata = zext ? {16'd0, d[15:0]}
                             : {{16{d[15]}}, d[15:0]};
            end
            default: begin
                mbase = MASK_W;
                ldata = d;
            end
        endcase
        smask = mbase << off;
        sdata = wdata << {off, 3'b000};
    end

endmodule

// File: rtl/ysyx_23060111_lsu.sv
// Load/store unit: one request at a time onto the memory port.
// Define YSYX_23060111_LSU_MISALIGN_CHECK_EN to reject misaligned access.
module ysyx_23060111_lsu
    import ysyx_23060111_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] m_raddr,
    output logic        m_ren,
    input  logic [31:0] m_rdata,
    output logic [31:0] m_waddr,
    output logic [31:0] m_wdata,
    output logic [31:0] m_wmask,
    output logic        m_wen
);

    localparam logic [3:0] LAST = 4'(RD_LATENCY - 1);

    lsu_state_e  state;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        zext_q;
    logic [3:0]  cnt;

    logic        idle;
    logic        reject;
    logic [1:0]  a_off;
    logic [1:0]  a_size;
    logic        a_zext;
    logic [31:0] sdata;
    logic [31:0] ldata;
    logic [3:0]  smask;
    logic [31:0] waligned;

    assign idle     = (state == LSU_IDLE);
    assign a_off    = idle ? req_addr[1:0] : off_q;
    assign a_size   = idle ? req_size : size_q;
    assign a_zext   = idle ? req_unsigned : zext_q;
    assign waligned = {req_addr[31:2], 2'b00};

`ifdef YSYX_23060111_LSU_MISALIGN_CHECK_EN
    assign reject = misaligned(req_size, req_addr[1:0]);
`else
    assign reject = 1'b0;
`endif

    ysyx_23060111_lsu_align u_align (
        .off   (a_off),
        .size  (a_size),
        .zext  (a_zext),
        .wdata (req_wdata),
        .rdata (m_rdata),
        .sdata (sdata),
        .smask (smask),
        .ldata (ldata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LSU_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            m_raddr   <= 32'd0;
            m_ren     <= 1'b0;
            m_waddr   <= 32'd0;
            m_wdata   <= 32'd0;
            m_wmask   <= 32'd0;
            m_wen     <= 1'b0;
            off_q     <= 2'd0;
            size_q    <= 2'd0;
            zext_q    <= 1'b0;
            cnt       <= 4'd0;
        end else begin
            unique case (state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        off_q     <= req_addr[1:0];
                        size_q    <= req_size;
                        zext_q    <= req_unsigned;
                        rsp_err   <= reject;
                        if (reject) begin
                            state     <= LSU_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else if (req_wen) begin
                            state   <= LSU_WRITE;
                            m_wen   <= 1'b1;
                            m_waddr <= waligned;
                            m_wdata <= sdata;
                            m_wmask <= {28'd0, smask};
                        end else begin
                            state   <= LSU_READ;
                            m_ren   <= 1'b1;
                            m_raddr <= waligned;
                            cnt     <= 4'd0;
                        end
                    end
                end
                LSU_WRITE: begin
                    state     <= LSU_RESP;
                    m_wen     <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= 32'd0;
                end
                LSU_READ: begin
                    // sample exactly at the end of the read window
                    if (cnt == LAST) begin
                        state     <= LSU_RESP;
                        m_ren     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= ldata;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                LSU_RESP: begin
                    if (rsp_ready) begin
                        state     <= LSU_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060111_lsu.sv
// Self-checking bench for ysyx_23060111_lsu with RD_LATENCY=3.
// Directed plan cases followed by random requests vs a byte-level model.
module tb_ysyx_23060111_lsu;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] m_raddr;
    logic        m_ren;
    logic [31:0] m_rdata = 32'd0;
    logic [31:0] m_waddr;
    logic [31:0] m_wdata;
    logic [31:0] m_wmask;
    logic        m_wen;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_23060111_lsu #(.RD_LATENCY(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .m_raddr      (m_raddr),
        .m_ren        (m_ren),
        .m_rdata      (m_rdata),
        .m_waddr      (m_waddr),
        .m_wdata      (m_wdata),
        .m_wmask      (m_wmask),
        .m_wen        (m_wen)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%08h expected=%08h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic [1:0] size,
                                       input logic [1:0] off);
`ifdef YSYX_23060111_LSU_MISALIGN_CHECK_EN
        if (size == 2'd3) return 1'b1;
        if (size == 2'd2 && off != 2'd0) return 1'b1;
        if (size == 2'd1 && off[0]) return 1'b1;
        return 1'b0;
`else
        return (size == 2'd3) && (off == 2'd3) && 1'b0;
`endif
    endfunction

    function automatic int nbytes(input logic [1:0] size);
        if (size == 2'd0) return 1;
        if (size == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] exp_mask(input logic [1:0] size,
                                             input logic [1:0] off);
        logic [31:0] r = 32'd0;
        for (int i = 0; i < 4; i++)
            if (i >= int'(off) && i < int'(off) + nbytes(size))
                r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] w,
                                              input logic [1:0] off);
        logic [31:0] r = 32'd0;
        for (int j = 0; j < 4; j++)
            if (j >= int'(off))
                r[8*j +: 8] = w[8*(j-int'(off)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd,
                                             input logic [1:0] size,
                                             input logic [1:0] off,
                                             input logic uns);
        logic [31:0] r = 32'd0;
        int nb = nbytes(size);
        for (int j = 0; j < nb; j++)
            if (j + int'(off) < 4)
                r[8*j +: 8] = rd[8*(j+int'(off)) +: 8];
        if (nb < 4 && !uns && r[8*nb-1])
            for (int j = nb; j < 4; j++) r[8*j +: 8] = 8'hFF;
        return r;
    endfunction

    // Issue one request from a negedge with the DUT idle; ends on a negedge.
    task automatic run(input string name,
                       input logic wen,
                       input logic [31:0] addr,
                       input logic [31:0] wdata,
                       input logic [1:0] size,
                       input logic uns,
                       input logic [31:0] rdata,
                       input int bp);
        int wen_n = 0, ren_n = 0, rsp_at = 0;
        logic [31:0] cw_addr = 0, cw_data = 0, cw_mask = 0;
        logic [31:0] cr_addr = 0, held;
        logic err;
        int exp_at;
        err = model_err(size, addr[1:0]);
        chk({name, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_wen = wen; req_addr = addr;
        req_wdata = wdata; req_size = size; req_unsigned = uns;
        m_rdata = rdata;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_wdata = $urandom;
            if (m_wen) begin
                wen_n++;
                cw_addr = m_waddr; cw_data = m_wdata; cw_mask = m_wmask;
            end
            if (m_ren) begin
                if (ren_n == 0) cr_addr = m_raddr;
                ren_n++;
            end
            if (rsp_valid) begin
                rsp_at = k;
                break;
            end
        end
        exp_at = err ? 1 : (wen ? 2 : LAT + 1);
        chk({name, ".rsp_at"}, rsp_at, exp_at);
        chk({name, ".wen_n"}, wen_n, (wen && !err) ? 1 : 0);
        chk({name, ".ren_n"}, ren_n, (!wen && !err) ? LAT : 0);
        chk({name, ".err"}, {31'd0, rsp_err}, {31'd0, err});
        if (wen && !err) begin
            chk({name, ".waddr"}, cw_addr, {addr[31:2], 2'b00});
            chk({name, ".wmask"}, cw_mask, exp_mask(size, addr[1:0]));
            chk({name, ".wdata"}, cw_data, exp_wdata(wdata, addr[1:0]));
        end
        if (!wen && !err)
            chk({name, ".raddr"}, cr_addr, {addr[31:2], 2'b00});
        chk({name, ".rdata"}, rsp_rdata,
            (wen || err) ? 32'd0 : exp_load(rdata, size, addr[1:0], uns));
        held = rsp_rdata;
        req_valid = (bp > 0);
        req_wen = 1'b1;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk({name, ".bp_valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({name, ".bp_rdata"}, rsp_rdata, held);
            chk({name, ".bp_ready"}, {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({name, ".post_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({name, ".post_ready"}, {31'd0, req_ready}, 32'd1);
        chk({name, ".post_wen"}, {31'd0, m_wen}, 32'd0);
    endtask

    initial begin
        int wen_seen;
        repeat (2) @(negedge clk);
        chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'd0);
        chk("rst.m_ren", {31'd0, m_ren}, 32'd0);
        chk("rst.m_wen", {31'd0, m_wen}, 32'd0);
        chk("rst.m_wmask", m_wmask, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run("st_word", 1'b1, 32'h8000_0004, 32'hDEADBEEF, 2'd2, 1'b0, 0, 0);
        run("st_byte", 1'b1, 32'h8000_0003, 32'h0000_00AB, 2'd0, 1'b0, 0, 0);
        run("ld_h_s", 1'b0, 32'h8000_0002, 0, 2'd1, 1'b0, 32'h8001_1234, 0);
        run("ld_h_u", 1'b0, 32'h8000_0002, 0, 2'd1, 1'b1, 32'h8001_1234, 0);
        run("ld_bp", 1'b0, 32'h8000_0000, 0, 2'd2, 1'b0, 32'hCAFE_F00D, 5);
        run("ld_b3", 1'b0, 32'h8000_0001, 0, 2'd0, 1'b0, 32'h0000_FF00, 0);
        run("ld_w_mis", 1'b0, 32'h8000_0002, 0, 2'd2, 1'b0, 32'h1122_3344, 0);
        run("st_h_mis", 1'b1, 32'h8000_0003, 32'h0000_BEEF, 2'd1, 1'b0, 0, 2);
        run("ld_sz3", 1'b0, 32'h8000_0000, 0, 2'd3, 1'b0, 32'h8765_4321, 0);

        for (int t = 0; t < 40; t++)
            run("rand", 1'($urandom), $urandom, $urandom,
                2'($urandom_range(0, 3)), 1'($urandom), $urandom,
                int'($urandom_range(0, 3)));

        // reset while a store is being driven onto the port
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0010;
        req_size = 2'd2; req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        chk("rstw.wen_before", {31'd0, m_wen}, 32'd1);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstw.wen_after", {31'd0, m_wen}, 32'd0);
        chk("rstw.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rstw.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wen_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (m_wen || rsp_valid) wen_seen++;
        end
        chk("rstw.no_replay", wen_seen, 0);
        chk("rstw.idle", {31'd0, req_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
